// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if: ciphertext/plaintext handshake plus round-key store lookup for aes_inv_cipher_iter
interface aes_inv_cipher_iter_if #(parameter int KIDX_W = 4);
  logic in_valid;
  logic in_ready;
  logic [127:0] cipher_in;
  logic [KIDX_W-1:0] key_idx;
  logic [127:0] round_key;
  logic out_valid;
  logic out_ready;
  logic [127:0] plain_out;
  logic busy;
  modport master(output in_valid, cipher_in, round_key, out_ready, input in_ready, key_idx, out_valid, plain_out, busy);
  modport slave(input in_valid, cipher_in, round_key, out_ready, output in_ready, key_idx, out_valid, plain_out, busy);
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: one-round-per-clock AES-128 InvCipher; AES_INV_EARLY_ACCEPT_EN lets DONE accept the next block
module aes_inv_cipher_iter #(
  parameter int NR = 10,
  parameter int KIDX_W = 4
) (
  input logic clk,
  input logic rst_n,
  aes_inv_cipher_iter_if.slave bus
);
  if (NR != 10) begin : g_bad_nr
    $error("aes_inv_cipher_iter supports NR=10 only");
  end
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  fsm_t fsm, fsm_d;
  logic [127:0] st, st_d, pt, pt_d;
  logic [3:0] rnd, rnd_d;
  logic ov, ov_d, acc;
  logic [127:0] isb, ark, imc;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // inverse affine, then GF(2^8) inversion as a^254 (maps 0 to 0)
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] a, a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    a2 = gmul(a, a);
    a3 = gmul(a2, a);
    a6 = gmul(a3, a3);
    a12 = gmul(a6, a6);
    a15 = gmul(a12, a3);
    a30 = gmul(a15, a15);
    a60 = gmul(a30, a30);
    a120 = gmul(a60, a60);
    a240 = gmul(a120, a120);
    return gmul(gmul(a240, a12), a2);
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction
  assign isb = inv_sub_bytes(inv_shift_rows(st));
  assign ark = isb ^ bus.round_key;
  assign imc = inv_mix_columns(ark);
`ifdef AES_INV_EARLY_ACCEPT_EN
  assign bus.in_ready = (fsm == IDLE) | ((fsm == DONE) & bus.out_ready);
`else
  assign bus.in_ready = fsm == IDLE;
`endif
  assign acc = bus.in_valid & bus.in_ready;
  // DONE presents w[NR] so an early accept sees the initial round key
  assign bus.key_idx = (fsm == ROUND) ? KIDX_W'(rnd) : (fsm == FINAL) ? '0 : KIDX_W'(NR);
  assign bus.busy = (fsm == ROUND) | (fsm == FINAL);
  assign bus.out_valid = ov;
  assign bus.plain_out = pt;
  always_comb begin
    fsm_d = fsm;
    st_d = st;
    rnd_d = rnd;
    pt_d = pt;
    ov_d = ov;
    unique case (fsm)
      IDLE: if (acc) begin
        st_d = bus.cipher_in ^ bus.round_key;
        rnd_d = 4'(NR - 1);
        fsm_d = ROUND;
      end
      ROUND: begin
        st_d = imc;
        rnd_d = (rnd == 4'd1) ? rnd : rnd - 4'd1;
        fsm_d = (rnd == 4'd1) ? FINAL : ROUND;
      end
      FINAL: begin
        pt_d = ark;
        ov_d = 1'b1;
        fsm_d = DONE;
      end
      DONE: if (bus.out_ready) begin
        ov_d = 1'b0;
        fsm_d = IDLE;
`ifdef AES_INV_EARLY_ACCEPT_EN
        if (acc) begin
          st_d = bus.cipher_in ^ bus.round_key;
          rnd_d = 4'(NR - 1);
          fsm_d = ROUND;
        end
`endif
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= IDLE;
      st <= '0;
      rnd <= '0;
      pt <= '0;
      ov <= 1'b0;
    end else begin
      fsm <= fsm_d;
      st <= st_d;
      rnd <= rnd_d;
      pt <= pt_d;
      ov <= ov_d;
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: FIPS-197 vectors, backpressure, mid-round reset and back-to-back against a byte-level model
module tb_aes_inv_cipher_iter;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CTC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] sb [256];
  logic [7:0] isb_t [256];
  logic [127:0] rk [0:10];
  int m_cnt = 0;
  logic m_ov = 1'b0;
  logic [127:0] m_pt = '0;
  logic [127:0] m_pend = '0;
  aes_inv_cipher_iter_if #(.KIDX_W(4)) bus();
  aes_inv_cipher_iter dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign bus.round_key = (bus.key_idx <= 4'd10) ? rk[bus.key_idx] : '0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int x = a, y = b, p = 0;
    while (y != 0) begin
      if ((y & 1) != 0) p ^= x;
      x = x << 1;
      if ((x & 'h100) != 0) x ^= 'h11b;
      y >>= 1;
    end
    return 8'(p);
  endfunction
  function automatic int rotl8(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction
  task automatic load_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] coef [4];
    logic [127:0] o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rk[10][127-8*k -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int k = 0; k < 16; k++)
        t[k] = isb_t[s[4*(((k/4) + 4 - (k%4)) % 4) + k%4]] ^ rk[rd][127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          s[4*c+r] = (rd == 0) ? t[4*c+r] : 8'h00;
          if (rd != 0)
            for (int j = 0; j < 4; j++) s[4*c+r] ^= gm(coef[(j - r + 4) % 4], t[4*c+j]);
        end
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction
  function automatic logic exp_ir();
`ifdef AES_INV_EARLY_ACCEPT_EN
    return (m_cnt == 0 && !m_ov) || (m_ov && bus.out_ready);
`else
    return m_cnt == 0 && !m_ov;
`endif
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_ov = 1'b0;
    end else begin
      logic acc;
      acc = bus.in_valid && exp_ir();
      if (m_ov && bus.out_ready) m_ov = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ov = 1'b1;
          m_pt = m_pend;
        end
      end
      if (acc) begin
        m_cnt = 10;
        m_pend = model_dec(bus.cipher_in);
      end
    end
  end
  always @(negedge clk) begin
    chk("in_ready", 128'(bus.in_ready), 128'(exp_ir()));
    chk("busy", 128'(bus.busy), 128'(m_cnt > 0));
    chk("out_valid", 128'(bus.out_valid), 128'(m_ov));
    chk("key_idx", 128'(bus.key_idx), 128'((m_cnt > 0) ? m_cnt - 1 : 10));
    if (m_ov) chk("plain_out", bus.plain_out, m_pt);
  end
  task automatic accept(input logic [127:0] ct, input logic [127:0] key);
    int g = 0;
    load_key(key);
    bus.cipher_in = ct;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && g < 30) begin
      tick();
      g++;
    end
    if (!bus.in_ready) chk("accept_timeout", 128'(0), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    bus.cipher_in = ~ct;
  endtask
  task automatic wait_ov(output int k);
    k = 0;
    while (!bus.out_valid && k < 30) begin
      tick();
      k++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 128'(0), 128'(1));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, t1, t2;
    for (int x = 0; x < 256; x++) begin
      int inv, s;
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = y;
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
      sb[x] = 8'(s);
      isb_t[s] = 8'(x);
    end
    bus.in_valid = 1'b0;
    bus.cipher_in = '0;
    bus.out_ready = 1'b0;
    load_key(KB);
    chk("model_w10_B", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_dec_B", model_dec(CTB), PTB);
    load_key(KC);
    chk("model_dec_C1", model_dec(CTC), PTC);
    repeat (2) tick();
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_plain_out", bus.plain_out, 128'(0));
    chk("rst_key_idx", 128'(bus.key_idx), 128'(10));
    rst_n = 1'b1;
    tick();
    accept(CTB, KB);
    chk("B_state_after_accept", dut.st, CTB ^ 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (9) tick();
    chk("B_state_before_last_ark", dut.isb, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("B_not_valid_at_9", 128'(bus.out_valid), 128'(0));
    tick();
    chk("B_valid_at_10", 128'(bus.out_valid), 128'(1));
    chk("B_plain", bus.plain_out, PTB);
    bus.out_ready = 1'b1;
    tick();
    chk("B_released", 128'(bus.out_valid), 128'(0));
    chk("C1_key_idx_idle", 128'(bus.key_idx), 128'(10));
    accept(CTC, KC);
    for (int i = 0; i < 10; i++) begin
      chk("C1_key_idx_seq", 128'(bus.key_idx), 128'(9 - i));
      tick();
    end
    chk("C1_valid", 128'(bus.out_valid), 128'(1));
    chk("C1_plain", bus.plain_out, PTC);
    tick();
    bus.out_ready = 1'b0;
    accept(CTB, KB);
    wait_ov(k);
    chk("bp_latency", 128'(k), 128'(10));
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 128'(bus.out_valid), 128'(1));
      chk("bp_plain", bus.plain_out, PTB);
      chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
      bus.in_valid = i[0];
      bus.cipher_in = CTC;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_released", 128'(bus.out_valid), 128'(0));
    chk("bp_no_accept", 128'(bus.busy), 128'(0));
    accept(CTC, KC);
    repeat (4) tick();
    chk("rst_mid_key_idx", 128'(bus.key_idx), 128'(5));
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_mid_plain", bus.plain_out, 128'(0));
    chk("rst_mid_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_mid_busy", 128'(bus.busy), 128'(0));
    chk("rst_mid_key_idx_idle", 128'(bus.key_idx), 128'(10));
    #2 rst_n = 1'b1;
    tick();
    accept(CTC, KC);
    wait_ov(k);
    chk("rst_after_latency", 128'(k), 128'(10));
    chk("rst_after_plain", bus.plain_out, PTC);
    tick();
    accept(CTB, KB);
    wait_ov(k);
    t1 = cyc;
    chk("b2b_first_plain", bus.plain_out, PTB);
    accept(CTC, KC);
    wait_ov(k);
    t2 = cyc;
    chk("b2b_second_plain", bus.plain_out, PTC);
`ifdef AES_INV_EARLY_ACCEPT_EN
    chk("b2b_gap", 128'(t2 - t1), 128'(11));
`else
    chk("b2b_gap", 128'(t2 - t1), 128'(12));
`endif
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
